// File: rtl/encrypt_pkg.sv
// Shared tables and helpers for the encrypt pipeline: nibble S-boxes, rotates,
// round-constant rule and the forward/backward key-schedule steps.
package encrypt_pkg;

    localparam int ROUNDS_DEF = 4;
    localparam int ROUNDS_MIN = 1;
    localparam int ROUNDS_MAX = 8;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return {SBOX[x[7:4]], SBOX[x[3:0]]};
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
        return {INV_SBOX[x[7:4]], INV_SBOX[x[3:0]]};
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] rotr1(input logic [7:0] x);
        return {x[0], x[7:1]};
    endfunction

    function automatic logic [7:0] rotl3(input logic [7:0] x);
        return {x[4:0], x[7:5]};
    endfunction

    function automatic logic [7:0] rotr3(input logic [7:0] x);
        return {x[2:0], x[7:3]};
    endfunction

    // Round constant mixed into the key when stepping from k(i) to k(i+1).
    function automatic logic [7:0] rcon(input int i);
        return 8'(i + 1);
    endfunction

    function automatic logic [7:0] key_next(input logic [7:0] k, input int i);
        return rotl1(k) ^ rcon(i);
    endfunction

    // Inverse of key_next: recovers k(i) from k(i+1).
    function automatic logic [7:0] key_prev(input logic [7:0] k, input int i);
        return rotr1(k ^ rcon(i));
    endfunction

    function automatic logic [7:0] key_at(input logic [7:0] k0, input int n);
        logic [7:0] k;
        k = k0;
        for (int i = 0; i < n; i++) begin
            k = key_next(k, i);
        end
        return k;
    endfunction

endpackage

// File: rtl/encrypt_round.sv
// One registered cipher round: data, its key and valid in; next-stage data,
// next-stage key and valid out. Decrypt path present with ENCRYPT_DECRYPT_EN.
module encrypt_round
    import encrypt_pkg::*;
#(
    parameter int IDX     = 0,
`ifdef ENCRYPT_DECRYPT_EN
    parameter int DEC_IDX = 0,
`endif
    parameter bit LAST    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vld_i,
    input  logic [7:0] data_i,
    input  logic [7:0] key_i,
`ifdef ENCRYPT_DECRYPT_EN
    input  logic       mode_i,
    output logic       mode_o,
`endif
    output logic       vld_o,
    output logic [7:0] data_o,
    output logic [7:0] key_o
);

    logic [7:0] data_d;
    logic [7:0] key_d;
    logic [7:0] data_q;
    logic [7:0] key_q;
    logic       vld_q;
    logic [7:0] s_nxt;
    logic [7:0] k_nxt;

    // Both directions consume the incoming key before the nonlinear step, so the
    // last stage only adds the whitening XOR with the key it just produced.
    always_comb begin
        s_nxt = rotl3(sub_byte(data_i ^ key_i));
        k_nxt = key_next(key_i, IDX);
`ifdef ENCRYPT_DECRYPT_EN
        if (mode_i) begin
            s_nxt = inv_sub_byte(rotr3(data_i ^ key_i));
            k_nxt = key_prev(key_i, DEC_IDX);
        end
`endif
        data_d = LAST ? (s_nxt ^ k_nxt) : s_nxt;
        key_d  = k_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_i) begin
            key_q <= key_d;
        end
    end

`ifdef ENCRYPT_DECRYPT_EN
    logic mode_q;
    always_ff @(posedge clk) begin
        if (vld_i) begin
            mode_q <= mode_i;
        end
    end
    assign mode_o = mode_q;
`endif

    // Only the final stage is the visible result, so only it is cleared.
    if (LAST) begin : g_last
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= 8'h00;
            end else if (vld_i) begin
                data_q <= data_d;
            end
        end
    end else begin : g_mid
        always_ff @(posedge clk) begin
            if (vld_i) begin
                data_q <= data_d;
            end
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign key_o  = key_q;

endmodule

// File: rtl/encrypt.sv
// Fully unrolled byte cipher: one input register then ROUNDS encrypt_round stages.
// Optional decrypt mode enabled by defining ENCRYPT_DECRYPT_EN.
module encrypt
    import encrypt_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] key,
`ifdef ENCRYPT_DECRYPT_EN
    input  logic       mode,
`endif
    input  logic [7:0] inp,
    output logic [7:0] out,
    output logic       out_valid
);

    if (ROUNDS < ROUNDS_MIN || ROUNDS > ROUNDS_MAX) begin : g_bad_rounds
        $error("encrypt: ROUNDS out of range 1..8");
    end

    logic       stg_vld  [0:ROUNDS];
    logic [7:0] stg_data [0:ROUNDS];
    logic [7:0] stg_key  [0:ROUNDS];

    logic       vld_q;
    logic [7:0] data_q;
    logic [7:0] key_q;
    logic [7:0] key_d;

`ifdef ENCRYPT_DECRYPT_EN
    logic stg_mode [0:ROUNDS];
    logic mode_q;

    // Decrypt walks the schedule backwards, so it starts from k(ROUNDS).
    always_comb begin
        key_d = mode ? key_at(key, ROUNDS) : key;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mode_q <= mode;
        end
    end
    assign stg_mode[0] = mode_q;
`else
    always_comb begin
        key_d = key;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            data_q <= inp;
            key_q  <= key_d;
        end
    end

    assign stg_vld[0]  = vld_q;
    assign stg_data[0] = data_q;
    assign stg_key[0]  = key_q;

    for (genvar g = 0; g < ROUNDS; g++) begin : g_round
        encrypt_round #(
            .IDX     (g),
`ifdef ENCRYPT_DECRYPT_EN
            .DEC_IDX (ROUNDS - 1 - g),
`endif
            .LAST    (g == ROUNDS - 1)
        ) u_round (
            .clk    (clk),
            .rst_n  (rst_n),
            .vld_i  (stg_vld[g]),
            .data_i (stg_data[g]),
            .key_i  (stg_key[g]),
`ifdef ENCRYPT_DECRYPT_EN
            .mode_i (stg_mode[g]),
            .mode_o (stg_mode[g+1]),
`endif
            .vld_o  (stg_vld[g+1]),
            .data_o (stg_data[g+1]),
            .key_o  (stg_key[g+1])
        );
    end

    assign out       = stg_data[ROUNDS];
    assign out_valid = stg_vld[ROUNDS];

endmodule

// File: tb/tb_encrypt.sv
// Directed and randomized checks of encrypt against a behavioural cipher model;
// decrypt checks are included when ENCRYPT_DECRYPT_EN is defined.
module tb_encrypt;

    localparam int R    = 4;
    localparam int MAXC = 4096;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] key;
    logic [7:0] inp;
    logic       mode_r;
    logic [7:0] out;
    logic       out_valid;

    int compared;
    int mismatched;
    int cyc;

    logic       exp_v [0:MAXC-1];
    logic [7:0] exp_d [0:MAXC-1];
    logic [7:0] last_out;

    logic [3:0] sb  [0:15];
    logic [3:0] isb [0:15];

    encrypt #(.ROUNDS(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .key       (key),
`ifdef ENCRYPT_DECRYPT_EN
        .mode      (mode_r),
`endif
        .inp       (inp),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sched(input logic [7:0] k0, input int n);
        logic [7:0] k;
        k = k0;
        for (int i = 0; i < n; i++) k = {k[6:0], k[7]} ^ 8'(i + 1);
        return k;
    endfunction

    function automatic logic [7:0] model_enc(input logic [7:0] p, input logic [7:0] k0);
        logic [7:0] s;
        logic [7:0] t;
        s = p;
        for (int i = 0; i < R; i++) begin
            t = s ^ sched(k0, i);
            t = {sb[t[7:4]], sb[t[3:0]]};
            s = {t[4:0], t[7:5]};
        end
        return s ^ sched(k0, R);
    endfunction

    function automatic logic [7:0] model_dec(input logic [7:0] c, input logic [7:0] k0);
        logic [7:0] s;
        logic [7:0] t;
        s = c ^ sched(k0, R);
        for (int i = R - 1; i >= 0; i--) begin
            t = {s[2:0], s[7:3]};
            s = {isb[t[7:4]], isb[t[3:0]]} ^ sched(k0, i);
        end
        return s;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%02h expected=%02h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_outputs();
        check1("out_valid", out_valid, exp_v[cyc]);
        if (exp_v[cyc]) last_out = exp_d[cyc];
        check8("out", out, last_out);
    endtask

    task automatic step_exp(input logic v, input logic [7:0] d, input logic [7:0] k,
                            input logic m, input logic [7:0] e);
        in_valid = v;
        inp      = d;
        key      = k;
        mode_r   = m;
        if (v) begin
            exp_v[cyc + 1 + R] = 1'b1;
            exp_d[cyc + 1 + R] = e;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [7:0] k, input logic m);
        step_exp(v, d, k, m, m ? model_dec(d, k) : model_enc(d, k));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = cyc + 1; i < MAXC; i++) exp_v[i] = 1'b0;
        last_out = 8'h00;
        check8("rst_out", out, 8'h00);
        check1("rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rk;
        logic       rv;
        logic       rm;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        for (int i = 0; i < 16; i++) isb[sb[i]] = 4'(i);
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 8'h00;
        end
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        last_out   = 8'h00;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        inp        = 8'h00;
        key        = 8'h00;
        mode_r     = 1'b0;

        @(negedge clk);
        do_reset();
        idle(2);

        // Single pulse: result appears exactly five cycles later.
        step(1'b1, 8'hA5, 8'h3C, 1'b0);
        idle(4);
        check8("single_A5", out, 8'h01);
        check1("single_vld", out_valid, 1'b1);
        idle(1);
        check1("single_pulse_len", out_valid, 1'b0);
        idle(2);

        // Back-to-back stream.
        step(1'b1, 8'hA5, 8'h3C, 1'b0);
        step(1'b1, 8'h00, 8'h3C, 1'b0);
        idle(3);
        check8("stream_0", out, 8'h01);
        idle(1);
        check8("stream_1", out, 8'hBD);
        idle(3);
        check8("hold_last", out, 8'hBD);

        // Key change right after a capture must not disturb that byte.
        step(1'b1, 8'hA5, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 8'h00, 8'h00, 1'b0);
        idle(2);
        check8("keychg_first", out, 8'h01);
        idle(4);

        // Reset two cycles after a capture discards the byte.
        step(1'b1, 8'h5A, 8'h3C, 1'b0);
        idle(2);
        do_reset();
        idle(6);
        check8("post_rst_out", out, 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            rv = 1'($urandom_range(0, 3) != 0);
            rd = 8'($urandom);
            rk = (n % 7 == 0) ? 8'($urandom) : rk;
`ifdef ENCRYPT_DECRYPT_EN
            rm = 1'($urandom_range(0, 1));
`else
            rm = 1'b0;
`endif
            step(rv, rd, rk, rm);
        end
        idle(R + 2);

        // Mid-stream reset while the pipeline is full.
        for (int n = 0; n < 3; n++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        do_reset();
        idle(R + 2);

`ifdef ENCRYPT_DECRYPT_EN
        step(1'b1, 8'hBD, 8'h3C, 1'b1);
        idle(4);
        check8("dec_BD", out, 8'h00);
        idle(2);
        for (int i = 0; i < 256; i++) begin
            rk = 8'($urandom);
            step_exp(1'b1, model_enc(8'(i), rk), rk, 1'b1, 8'(i));
        end
        idle(R + 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/encrypt.md
ENCRYPT -- requirements
Module: encrypt

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 4, giving the number of cipher rounds; legal range 1..8.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; clk input 1 is the rising-edge clock of all state.
REQ-003 rst_n input 1 SHALL be the asynchronous, active-low reset.
REQ-004 in_valid input 1 SHALL qualify inp and key for capture.
REQ-005 key input 8 SHALL be the cipher key.
REQ-006 inp input 8 SHALL be the plaintext byte, or the ciphertext byte in decrypt mode.
REQ-007 out output 8 SHALL be the result byte.
REQ-008 out_valid output 1 SHALL pulse high for one cycle per result.

Function
REQ-009 The S-box S(0..F) SHALL be C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2, applied to each nibble independently.
REQ-010 Key schedule SHALL be k0 = key and k(i+1) = rotl1(k(i)) XOR (i+1), 8-bit, for i = 0..ROUNDS-1.
REQ-011 Round i SHALL compute s = rotl3(Sbox(s XOR k(i))), with rotl3 being an 8-bit rotate left by 3.
REQ-012 The final output SHALL be s XOR k(ROUNDS), with the initial s equal to inp.
REQ-013 The datapath SHALL be a fully unrolled pipeline:
- one input register stage, then one register stage per round;
- the final whitening SHALL merge into the last stage;
- latency SHALL be ROUNDS+1 clock cycles, i.e. 5 cycles at the default.
REQ-014 Throughput SHALL be one byte per cycle, with no backpressure and no stall.
REQ-015 The key SHALL travel down the pipeline alongside its data, so each in-flight byte uses the key captured with it.
REQ-016 A key change SHALL therefore affect only subsequent captures.
REQ-017 out_valid SHALL equal in_valid delayed by exactly ROUNDS+1 cycles.
REQ-018 out SHALL update only when out_valid is asserted and SHALL otherwise hold its last result.
REQ-019 Back-to-back in_valid over N cycles SHALL yield N consecutive out_valid cycles in the same order.

Reset
REQ-020 rst_n low SHALL asynchronously clear out to 8'h00, out_valid to 0, and all stage valid bits to 0.
REQ-021 Stage data registers need not be cleared on reset.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight bytes, and no out_valid SHALL appear for them.
REQ-023 After rst_n deasserts, the first capture SHALL occur on the first rising edge with in_valid high.

Configuration
REQ-024 Macro ENCRYPT_DECRYPT_EN defined SHALL add input port mode (width 1) after key, captured with in_valid and carried down the pipeline.
REQ-025 mode=0 SHALL encrypt.
REQ-026 mode=1 SHALL decrypt:
- s = inp XOR k(ROUNDS);
- for i = ROUNDS-1 down to 0: s = InvSbox(rotr3(s)) XOR k(i);
- latency SHALL be identical to encryption.
REQ-027 Without the macro, port mode SHALL NOT exist and the block SHALL encrypt only.

Structure
REQ-028 A shared package SHALL hold the S-box and inverse S-box tables, the rotate helper functions, and the round-constant rule.
REQ-029 The package SHALL also hold the ROUNDS default and limit constants.
REQ-030 One sub-module, encrypt_round, SHALL implement a single registered round (data, key and valid in; next-stage data, next-stage key and valid out).
REQ-031 encrypt SHALL instantiate encrypt_round ROUNDS times.

Verification
REQ-032 With ROUNDS=4, key=3C, inp=A5 and a single in_valid pulse, out SHALL be 01 with out_valid high exactly 5 cycles later.
REQ-033 With ROUNDS=4, key=3C, inp=00, out SHALL be BD.
REQ-034 Streaming inp=A5,00 on consecutive cycles with key=3C SHALL give out 01 then BD on consecutive out_valid cycles.
REQ-035 Capturing A5/3C, changing key to 00 on the next cycle, then capturing 00 SHALL give out 01 for the first byte, unaffected by the key change.
REQ-036 Asserting rst_n low 2 cycles after a capture SHALL clear out to 00 and produce no out_valid for that byte.
REQ-037 With ENCRYPT_DECRYPT_EN, mode=1, key=3C, inp=BD, out SHALL be 00; a random encrypt-then-decrypt round trip over 256 inputs SHALL return each input.
